// File: rtl/alu_dword_seq_pkg.sv
// alu_dword_seq_pkg: op codes, ALU function selects and FSM states for the dword ALU sequencer.
package alu_dword_seq_pkg;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_BAD = 2'd3;
    localparam logic [3:0] ALU_S_ADD = 4'd9;
    localparam logic [3:0] ALU_S_SUB = 4'd6;
    localparam logic [3:0] ALU_S_IDLE = 4'd0;
    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/alu_dword_seq_if.sv
// alu_dword_seq_if: control handshake plus external 16-bit ALU slice bus of the sequencer.
interface alu_dword_seq_if;
    logic start;
    logic [1:0] op;
    logic [31:0] opa, opb, res;
    logic busy, done, flg_c, flg_v, flg_z, err;
    logic alu_m, alu_cn_, alu_cn4_;
    logic [3:0] alu_s;
    logic [15:0] alu_a, alu_b, alu_f;
    modport master (
        output start, op, opa, opb, alu_f, alu_cn4_,
        input busy, done, res, flg_c, flg_v, flg_z, err, alu_m, alu_s, alu_cn_, alu_a, alu_b
    );
    modport slave (
        input start, op, opa, opb, alu_f, alu_cn4_,
        output busy, done, res, flg_c, flg_v, flg_z, err, alu_m, alu_s, alu_cn_, alu_a, alu_b
    );
endinterface

// File: rtl/alu_dword_seq_mul.sv
// alu_dword_seq_mul: shift-and-add multiply state (iteration counter, acc_hi/acc_lo), built only with ALU_SEQ_MUL_EN.
module alu_dword_seq_mul (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [15:0] mplier_i,
    input  logic [15:0] f_i,
    input  logic        c_i,
    output logic [15:0] acc_hi_o,
    output logic [15:0] acc_lo_o,
    output logic        last_o
);
    logic [15:0] hi_q, lo_q;
    logic [3:0] cnt_q;
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            hi_q <= '0;
            lo_q <= mplier_i;
            cnt_q <= '0;
        end else if (step_i) begin
            // {carry, sum, acc_lo} shifted right by one; the carry lands in acc_hi[15]
            hi_q <= {c_i, f_i[15:1]};
            lo_q <= {f_i[0], lo_q[15:1]};
            cnt_q <= cnt_q + 4'd1;
        end
    end
    assign acc_hi_o = hi_q;
    assign acc_lo_o = lo_q;
    assign last_o = cnt_q == 4'd15;
endmodule

// File: rtl/alu_dword_seq.sv
// alu_dword_seq: sequences 32-bit ADD/SUB (two 16-bit passes) and, with ALU_SEQ_MUL_EN, a 16x16 multiply
// over one external 16-bit ALU slice.
module alu_dword_seq
    import alu_dword_seq_pkg::*;
(
    input logic clk_sys,
    input logic rst,
    alu_dword_seq_if.slave bus
);
    state_t state_q;
    logic [15:0] a_q, b_q, lo_q, alu_a_q, alu_b_q;
    logic [31:0] res_q, hi_res_d;
    logic [3:0] alu_s_q;
    logic sub_q, c_q, v_q, z_q, err_q, alu_m_q, alu_cn_q;
    logic is_sub, is_mul, bad_op, v_d;
    assign is_sub = bus.op == OP_SUB;
    assign hi_res_d = {bus.alu_f, lo_q};
    assign v_d = (bus.alu_f[15] ^ a_q[15]) & ~(a_q[15] ^ b_q[15] ^ sub_q);
`ifdef ALU_SEQ_MUL_EN
    logic [15:0] acc_hi, acc_lo;
    logic [31:0] mul_res_d;
    logic last;
    assign is_mul = bus.op == OP_MUL;
    assign bad_op = bus.op == OP_BAD;
    alu_dword_seq_mul u_mul (
        .clk_sys (clk_sys),
        .rst     (rst),
        .load_i  (state_q == S_IDLE && bus.start),
        .step_i  (state_q == S_MUL),
        .mplier_i(bus.opb[15:0]),
        .f_i     (bus.alu_f),
        .c_i     (~bus.alu_cn4_),
        .acc_hi_o(acc_hi),
        .acc_lo_o(acc_lo),
        .last_o  (last)
    );
    assign bus.alu_a = state_q == S_MUL ? acc_hi : alu_a_q;
    assign bus.alu_b = state_q == S_MUL ? (acc_lo[0] ? a_q : 16'd0) : alu_b_q;
    assign mul_res_d = {~bus.alu_cn4_, bus.alu_f, acc_lo[15:1]};
`else
    assign is_mul = 1'b0;
    assign bad_op = bus.op[1];
    assign bus.alu_a = alu_a_q;
    assign bus.alu_b = alu_b_q;
`endif
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            {a_q, b_q, lo_q, alu_a_q, alu_b_q} <= '0;
            res_q <= '0;
            {sub_q, c_q, v_q, z_q, err_q} <= '0;
            alu_m_q <= 1'b1;
            alu_s_q <= ALU_S_IDLE;
            alu_cn_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    err_q <= bad_op;
                    sub_q <= is_sub;
                    a_q <= is_mul ? bus.opa[15:0] : bus.opa[31:16];
                    b_q <= bus.opb[31:16];
                    alu_a_q <= bad_op ? 16'd0 : bus.opa[15:0];
                    alu_b_q <= bad_op ? 16'd0 : bus.opb[15:0];
                    alu_m_q <= bad_op;
                    alu_s_q <= bad_op ? ALU_S_IDLE : is_sub ? ALU_S_SUB : ALU_S_ADD;
                    alu_cn_q <= ~is_sub;
                    state_q <= bad_op ? S_DONE : is_mul ? S_MUL : S_LO;
                end
                S_LO: begin
                    lo_q <= bus.alu_f;
                    alu_a_q <= a_q;
                    alu_b_q <= b_q;
                    alu_cn_q <= bus.alu_cn4_;
                    state_q <= S_HI;
                end
                S_HI: begin
                    res_q <= hi_res_d;
                    z_q <= hi_res_d == '0;
                    c_q <= ~bus.alu_cn4_;
                    v_q <= v_d;
                    {alu_a_q, alu_b_q} <= '0;
                    alu_m_q <= 1'b1;
                    alu_s_q <= ALU_S_IDLE;
                    alu_cn_q <= 1'b1;
                    state_q <= S_DONE;
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: if (last) begin
                    res_q <= mul_res_d;
                    z_q <= mul_res_d == '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                    {alu_a_q, alu_b_q} <= '0;
                    alu_m_q <= 1'b1;
                    alu_s_q <= ALU_S_IDLE;
                    alu_cn_q <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign bus.busy = state_q != S_IDLE;
    assign bus.done = state_q == S_DONE;
    assign bus.res = res_q;
    assign bus.flg_c = c_q;
    assign bus.flg_v = v_q;
    assign bus.flg_z = z_q;
    assign bus.err = err_q;
    assign bus.alu_m = alu_m_q;
    assign bus.alu_s = alu_s_q;
    assign bus.alu_cn_ = alu_cn_q;
endmodule

// File: tb/tb_alu_dword_seq.sv
// tb_alu_dword_seq: table-driven bench for alu_dword_seq with a behavioural 4x181+182 ALU slice.
module tb_alu_dword_seq;
    import alu_dword_seq_pkg::*;
    typedef struct {
        logic [1:0] op;
        logic [31:0] a, b, res;
        logic c, v, z, err;
        int lat;
    } vec_t;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] HS_OP = OP_MUL;
    localparam int HS_LAT = 17;
    localparam logic [31:0] HS_RES = 32'd15;
    localparam int RS_WAIT = 7;
`else
    localparam logic [1:0] HS_OP = OP_ADD;
    localparam int HS_LAT = 3;
    localparam logic [31:0] HS_RES = 32'd8;
    localparam int RS_WAIT = 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs[9];
    int nv;
    logic [16:0] sum;
    always #5 clk = ~clk;
    alu_dword_seq_if bus();
    alu_dword_seq dut (.clk_sys(clk), .rst(rst), .bus(bus));
    always_comb begin
        sum = 17'd0;
        if (bus.alu_s == 4'd9)
            sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, ~bus.alu_cn_};
        else if (bus.alu_s == 4'd6)
            sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {16'd0, ~bus.alu_cn_};
        bus.alu_f = bus.alu_m ? ~bus.alu_a : sum[15:0];
        bus.alu_cn4_ = bus.alu_m ? 1'b1 : ~sum[16];
    end
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask
    task automatic run(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = v.op;
        bus.opa = v.a;
        bus.opb = v.b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op = OP_BAD;
        bus.opa = $urandom;
        bus.opb = $urandom;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", idx, n, v.lat - 1);
        chk("res", idx, bus.res, v.res);
        chk("flg_c", idx, {31'd0, bus.flg_c}, {31'd0, v.c});
        chk("flg_v", idx, {31'd0, bus.flg_v}, {31'd0, v.v});
        chk("flg_z", idx, {31'd0, bus.flg_z}, {31'd0, v.z});
        chk("err", idx, {31'd0, bus.err}, {31'd0, v.err});
        @(posedge clk);
        #1;
        chk("done_pulse", idx, {31'd0, bus.done}, 32'd0);
        chk("busy_end", idx, {31'd0, bus.busy}, 32'd0);
    endtask
    initial begin
        int n, ndone;
        logic busy_ok;
        bus.start = 1'b0;
        bus.op = OP_ADD;
        bus.opa = '0;
        bus.opb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 0, {31'd0, bus.busy}, 32'd0);
        chk("rst_done", 0, {31'd0, bus.done}, 32'd0);
        chk("rst_res", 0, bus.res, 32'd0);
        chk("rst_alu", 0, {26'd0, bus.alu_m, bus.alu_s, bus.alu_cn_}, 32'h21);
        chk("rst_alu_ab", 0, {bus.alu_a, bus.alu_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vecs[0] = '{OP_ADD, 32'h0000_FFFF, 32'd1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[1] = '{OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        vecs[2] = '{OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        vecs[3] = '{OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[4] = '{OP_SUB, 32'd7, 32'd5, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[5] = '{OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3};
        vecs[6] = '{OP_BAD, 32'h1234_5678, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1};
`ifdef ALU_SEQ_MUL_EN
        vecs[7] = '{OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        vecs[8] = '{OP_MUL, 32'd1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 17};
        nv = 9;
`else
        vecs[7] = '{OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        nv = 8;
`endif
        for (int i = 0; i < nv; i++) run(vecs[i], i);
        chk("idle_alu", 0, {26'd0, bus.alu_m, bus.alu_s, bus.alu_cn_}, 32'h21);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = HS_OP;
        bus.opa = 32'd3;
        bus.opb = 32'd5;
        busy_ok = 1'b1;
        n = 0;
        @(posedge clk);
        #1;
        while (!bus.done && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_lat", 0, n, HS_LAT - 1);
        chk("hold_res", 0, bus.res, HS_RES);
        chk("hold_busy", 0, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("hold_pulse", 0, {31'd0, bus.done}, 32'd0);
        chk("hold_idle", 0, {31'd0, bus.busy}, 32'd0);
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("hold_restart", 0, ndone, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = HS_OP;
        bus.opa = 32'd3;
        bus.opb = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (RS_WAIT) @(posedge clk);
        #1;
        chk("rst_mid_busy_pre", 0, {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 0, {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_res", 0, bus.res, 32'd0);
        chk("rst_mid_done", 0, {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("rst_no_done", 0, ndone, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
